// File: rtl/magic_reader.sv
// Single-outstanding read bridge: latches a client selector, strobes the magic
// data source, and returns its data or a timeout error through a response handshake.
module magic_reader #(
    parameter int SEL_W   = 12,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_select,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [SEL_W-1:0]  read_select,
    output logic              read_ready,
    input  logic              read_valid,
    input  logic [DATA_W-1:0] read_data,
    output logic [15:0]       err_count
);

    // state | meaning
    // IDLE  | waiting for a client request (req_ready=1)
    // ISSUE | read strobe to the source, timeout counter running (read_ready=1)
    // RESP  | response held until the client takes it (resp_valid=1)
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [15:0] TC_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        state_q,   state_d;
    logic [SEL_W-1:0]  sel_q,     sel_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              err_q,     err_d;
    logic [15:0]       err_count_q, err_count_d;
    logic [15:0]       tcnt_q,    tcnt_d;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        data_d      = data_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        tcnt_d      = tcnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sel_d   = req_select;
                    tcnt_d  = 16'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (read_valid) begin
                    data_d  = read_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tcnt_q == TC_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                    // saturate rather than wrap so a stuck source stays visible
                    if (err_count_q != 16'hFFFF) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            err_count_q <= 16'd0;
            tcnt_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign read_ready  = (state_q == ISSUE);
    assign resp_valid  = (state_q == RESP);
    assign read_select = sel_q;
    assign resp_data   = data_q;
    assign resp_err    = err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_magic_reader.sv
// Scoreboard bench for magic_reader: expected responses are queued at request
// time and popped when resp_valid appears.
module tb_magic_reader;
    localparam int SEL_W  = 12;
    localparam int DATA_W = 64;
    localparam int TO     = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [SEL_W-1:0]  req_select = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [SEL_W-1:0]  read_select;
    logic              read_ready;
    logic              read_valid = 1'b0;
    logic [DATA_W-1:0] read_data = '0;
    logic [15:0]       err_count;

    magic_reader #(.SEL_W(SEL_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_select(req_select),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err), .read_select(read_select), .read_ready(read_ready),
        .read_valid(read_valid), .read_data(read_data), .err_count(err_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_errcnt = 16'd0;
    bit          src_en = 1'b0;

    function automatic logic [DATA_W-1:0] src_fn(input logic [SEL_W-1:0] s);
        return {32'hDEAD_BEEF, 20'h0, s};
    endfunction

    // Source model: real data only while strobed, junk otherwise so stray sampling shows.
    always @(negedge clock) begin
        if (src_en && read_ready) begin
            read_valid = 1'b1;
            read_data  = src_fn(read_select);
        end else begin
            read_valid = src_en;
            read_data  = {$urandom, $urandom};
        end
    end

    task automatic transact(input logic [SEL_W-1:0] sel, input bit ok, input int hold,
                            output int lat, output int rr);
        exp_t e;
        int   n;
        bit   got;
        src_en     = ok;
        req_valid  = 1'b1;
        req_select = sel;
        resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: req_ready=%b expected 1", req_ready);
        end
        e.err  = !ok;
        e.data = ok ? src_fn(sel) : '0;
        sb.push_back(e);
        if (!ok && exp_errcnt != 16'hFFFF) exp_errcnt = exp_errcnt + 16'd1;
        @(posedge clock);
        lat = 1;
        rr  = 0;
        got = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (read_select !== sel) begin
            errors++;
            $display("FAIL sel_latch: read_select=%h expected %h", read_select, sel);
        end
        for (int i = 0; i < 100; i++) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            rr += int'(read_ready);
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_wait: resp_valid=%b expected 1 within 100 cycles", resp_valid);
        end
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (resp_data !== e.data || resp_err !== e.err) begin
                errors++;
                $display("FAIL resp_value: data=%h err=%b expected data=%h err=%b",
                         resp_data, resp_err, e.data, e.err);
            end
            checks++;
            if (err_count !== exp_errcnt) begin
                errors++;
                $display("FAIL err_count: got %h expected %h", err_count, exp_errcnt);
            end
            for (int c = 0; c < hold; c++) begin
                @(negedge clock);
                checks++;
                if (resp_valid !== 1'b1 || resp_data !== e.data || resp_err !== e.err ||
                    req_ready !== 1'b0 || read_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure: cyc %0d rv=%b data=%h err=%b rq=%b rr=%b expected rv=1 data=%h err=%b rq=0 rr=0",
                             c, resp_valid, resp_data, resp_err, req_ready, read_ready, e.data, e.err);
                end
            end
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_release: resp_valid=%b req_ready=%b expected 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (read_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
            resp_data !== '0 || read_select !== '0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: rr=%b rv=%b err=%b data=%h sel=%h cnt=%h expected all zero",
                     read_ready, resp_valid, resp_err, resp_data, read_select, err_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_basic;
        int lat, rr;
        transact(12'h005, 1'b1, 0, lat, rr);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 2", lat);
        end
        transact(12'hFFF, 1'b1, 0, lat, rr);
        transact(12'h000, 1'b1, 0, lat, rr);
    endtask

    task automatic test_backpressure;
        int lat, rr;
        transact(12'h5A5, 1'b1, 5, lat, rr);
    endtask

    task automatic test_timeout;
        int lat, rr;
        transact(12'h077, 1'b0, 2, lat, rr);
        checks++;
        if (rr !== TO) begin
            errors++;
            $display("FAIL timeout_strobe: read_ready cycles %0d expected %0d", rr, TO);
        end
    endtask

    task automatic test_mid_reset;
        int lat, rr;
        src_en     = 1'b0;
        req_valid  = 1'b1;
        req_select = 12'h03C;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (read_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_issue: read_ready=%b expected 1", read_ready);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (read_ready !== 1'b0 || resp_valid !== 1'b0 || read_select !== '0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_abort: rr=%b rv=%b sel=%h cnt=%h expected 0 0 000 0000",
                     read_ready, resp_valid, read_select, err_count);
        end
        exp_errcnt = 16'd0;
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        transact(12'h0A1, 1'b1, 0, lat, rr);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL midrst_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_back_to_back;
        int             acc_cyc[$];
        logic [SEL_W-1:0] prev_sel;
        bit             acc_prev, acc_now, chg_sel, drop;
        exp_t           e;
        src_en     = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_select = 12'h111;
        prev_sel   = read_select;
        acc_prev   = 1'b0;
        chg_sel    = 1'b0;
        drop       = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (chg_sel) req_select = 12'h222;
            if (drop) req_valid = 1'b0;
            chg_sel = 1'b0;
            drop    = 1'b0;
            if (read_select !== prev_sel) begin
                checks++;
                if (!acc_prev) begin
                    errors++;
                    $display("FAIL b2b_sel_change: read_select=%h changed without accept, was %h", read_select, prev_sel);
                end
            end
            if (resp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_resp: data=%h expected no response", resp_data);
                end else begin
                    e = sb.pop_front();
                    if (resp_data !== e.data || resp_err !== e.err) begin
                        errors++;
                        $display("FAIL b2b_resp: data=%h err=%b expected data=%h err=%b",
                                 resp_data, resp_err, e.data, e.err);
                    end
                end
            end
            acc_now = req_valid && req_ready;
            if (acc_now) begin
                acc_cyc.push_back(cyc);
                e.err  = 1'b0;
                e.data = src_fn(req_select);
                sb.push_back(e);
                if (acc_cyc.size() == 1) chg_sel = 1'b1;
                else drop = 1'b1;
            end
            prev_sel = read_select;
            acc_prev = acc_now;
            @(negedge clock);
        end
        resp_ready = 1'b0;
        checks++;
        if (acc_cyc.size() != 2 || (acc_cyc.size() == 2 && acc_cyc[1] - acc_cyc[0] != 3)) begin
            errors++;
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d expected 2 accepts gap 3",
                     acc_cyc.size(), (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_missing: %0d responses outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_saturation;
        int lat, rr;
        dut.err_count_q = 16'hFFFD;
        exp_errcnt      = 16'hFFFD;
        for (int k = 0; k < 4; k++) begin
            transact(12'h100 + 12'(k), 1'b0, 0, lat, rr);
        end
        checks++;
        if (err_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation: err_count=%h expected ffff", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/magic_reader.md
MAGIC_READER -- requirements
Module: magic_reader

Interface
REQ-001 SHALL have parameter SEL_W, default 12, width of the read selector.
REQ-002 SHALL have parameter DATA_W, default 64, width of returned data.
REQ-003 SHALL have parameter TIMEOUT, default 16, ISSUE cycles without read_valid before an error response; legal range 2..65535.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port req_valid  input  1  client read request valid.
REQ-007 SHALL have port req_ready  output  1  block accepts a request.
REQ-008 SHALL have port req_select  input  SEL_W  client selector.
REQ-009 SHALL have port resp_valid  output  1  response valid.
REQ-010 SHALL have port resp_ready  input  1  client accepts the response.
REQ-011 SHALL have port resp_data  output  DATA_W  returned data.
REQ-012 SHALL have port resp_err  output  1  response is a timeout error.
REQ-013 SHALL have port read_select  output  SEL_W  selector to the magic data source.
REQ-014 SHALL have port read_ready  output  1  read strobe to the magic data source.
REQ-015 SHALL have port read_valid  input  1  source has data.
REQ-016 SHALL have port read_data  input  DATA_W  source data; the source updates it on the falling edge inside a cycle where read_valid and read_ready are both 1.
REQ-017 SHALL have port err_count  output  16  saturating count of timeout responses.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, RESP; outputs decoded from registered state only.
REQ-019 req_ready SHALL be 1 exactly in IDLE; a request is accepted on a rising edge with req_valid and req_ready both 1.
REQ-020 On accept, req_select SHALL be latched into read_select, the timeout counter cleared, and the state SHALL become ISSUE.
REQ-021 read_select SHALL hold its latched value in ISSUE and RESP, and until the next accept.
REQ-022 read_ready SHALL be 1 exactly in ISSUE.
REQ-023 In ISSUE with read_valid=1 at the rising edge, read_data SHALL be captured into resp_data, resp_err set to 0, and the state SHALL become RESP; request-to-resp_valid latency is 2 cycles.
REQ-024 In ISSUE with read_valid=0, the timeout counter SHALL increment; when it equals TIMEOUT-1, the next edge SHALL enter RESP with resp_data=0, resp_err=1, and err_count+1.
REQ-025 err_count SHALL saturate at 16'hFFFF, never wrap.
REQ-026 resp_valid SHALL be 1 exactly in RESP; resp_data and resp_err SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-027 In RESP, resp_ready=1 at a rising edge SHALL return the state to IDLE; no request is accepted in that same cycle.
REQ-028 read_data SHALL be sampled only in ISSUE; changes in any other state SHALL not affect resp_data.
REQ-029 req_valid asserted outside IDLE SHALL be ignored; the client holds it until req_ready.
REQ-030 At most one outstanding read SHALL exist; read_ready is never 1 in two consecutive transactions without an intervening RESP.

Reset
REQ-031 reset=0 SHALL asynchronously force state IDLE, read_ready=0, resp_valid=0, resp_err=0, resp_data=0, read_select=0, err_count=0, timeout counter=0.
REQ-032 Reset during ISSUE or RESP SHALL abort the transaction with no response; the first accept after release behaves as from power-up.
REQ-033 After reset deasserts, req_ready SHALL be 1 in the first cycle.

Verification
REQ-034 Basic read: req_select=12'h005, source returns 64'hDEAD_BEEF_0000_0005 with read_valid=1 -> resp_valid 2 cycles after accept, resp_data=64'hDEAD_BEEF_0000_0005, resp_err=0.
REQ-035 Backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_data stable all 5 cycles, req_ready=0, read_ready=0.
REQ-036 Timeout: TIMEOUT=4, read_valid held 0 -> read_ready high 4 cycles, then resp_err=1, resp_data=0, err_count=1.
REQ-037 Saturation: force 65536 timeouts -> err_count stays 16'hFFFF.
REQ-038 Mid-operation reset: reset=0 in ISSUE -> read_ready=0 and resp_valid=0 immediately; next request select 12'h0A1 completes normally.
REQ-039 Back-to-back: two requests with resp_ready=1 always -> accepts 3 cycles apart, read_select changes only at each accept.
